// File: rtl/dma_pkg.sv
// dma_pkg -- shared types and constants for the DMA burst scheduler and the
// AXI copy engine that consumes its commands.
//   state_e        : scheduler FSM encoding (also exported for debug)
//   BOUNDARY_WORDS : words per 4KB AXI boundary window
//   LEN_W          : AXI ARLEN/AWLEN width
//   BEAT_W         : width used for beat arithmetic (holds 0..1024 plus headroom)
//   min_u          : unsigned minimum helper used by the beat calculator
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int BOUNDARY_WORDS = 1024;
    localparam int LEN_W          = 8;
    localparam int BEAT_W         = 11;

    function automatic logic [BEAT_W-1:0] min_u(input logic [BEAT_W-1:0] a,
                                                input logic [BEAT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dma_beat_calc.sv
// dma_beat_calc -- purely combinational minimum of four beat limits.
// Ports:
//   max_beats  in  BEAT_W  configured burst ceiling
//   remain     in  BEAT_W  remaining words, already clipped to BEAT_W range
//   s_room     in  BEAT_W  words left before the source 4KB boundary
//   d_room     in  BEAT_W  words left before the destination 4KB boundary
//   beats      out BEAT_W  smallest of the four
module dma_beat_calc
    import dma_pkg::*;
(
    input  logic [BEAT_W-1:0] max_beats,
    input  logic [BEAT_W-1:0] remain,
    input  logic [BEAT_W-1:0] s_room,
    input  logic [BEAT_W-1:0] d_room,
    output logic [BEAT_W-1:0] beats
);

    logic [BEAT_W-1:0] min_a;
    logic [BEAT_W-1:0] min_b;

    // Balanced tree keeps the compare depth at two levels.
    always_comb begin
        min_a = min_u(max_beats, remain);
        min_b = min_u(s_room, d_room);
        beats = min_u(min_a, min_b);
    end

endmodule

// File: rtl/dma_burst_sched.sv
// dma_burst_sched -- turns one programmed DMA job (saddr/daddr/number) into a
// sequence of AXI-legal burst commands, none crossing a 4KB boundary on either
// side, and pulses dma_axi_done when the last burst has completed.
// Ports:
//   hclk, hreset       clock; synchronous active-low reset
//   dma_axi_start      1-cycle job start
//   dma_cfg_saddr/daddr/number  job configuration, sampled only on accepted start
//   cmd_valid/cmd_ready         burst command handshake
//   cmd_saddr/daddr/len         burst command payload (len = beats-1)
//   burst_done         engine finished the accepted burst
//   dma_axi_done       1-cycle job completion pulse
//   busy               job in progress (start accepted .. done cycle inclusive)
//   start_err          1-cycle pulse: start arrived while not idle
//   dbg_state          current FSM state
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// Once cmd_valid rises, cmd_valid and cmd_saddr/daddr/len stay constant until
// that transfer; cmd_valid never depends combinationally on cmd_ready.
module dma_burst_sched
    import dma_pkg::*;
#(
    parameter int MAX_BEATS = 16,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 14
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              dma_axi_start,
    input  logic [ADDR_W-1:0] dma_cfg_saddr,
    input  logic [ADDR_W-1:0] dma_cfg_daddr,
    input  logic [CNT_W-1:0]  dma_cfg_number,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_saddr,
    output logic [ADDR_W-1:0] cmd_daddr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              burst_done,
    output logic              dma_axi_done,
    output logic              busy,
    output logic              start_err,
    output state_e            dbg_state
);

    localparam logic [BEAT_W-1:0] MAX_B    = BEAT_W'(MAX_BEATS);
    localparam logic [BEAT_W-1:0] BND_W    = BEAT_W'(BOUNDARY_WORDS);
    localparam logic [CNT_W-1:0]  BND_CNT  = CNT_W'(BOUNDARY_WORDS);

    state_e            state;
    state_e            state_nxt;

    logic [ADDR_W-1:0] cur_s;
    logic [ADDR_W-1:0] cur_d;
    logic [CNT_W-1:0]  remain;
    logic [BEAT_W-1:0] beats_q;

    logic [BEAT_W-1:0] remain_clip;
    logic [BEAT_W-1:0] s_room;
    logic [BEAT_W-1:0] d_room;
    logic [BEAT_W-1:0] beats;

    logic              last_burst;

    // ------------------------------------------------------------------
    // Beat limit: no burst ever needs more than one boundary window, so
    // large remaining counts are clipped to 1024 before the compare.
    // ------------------------------------------------------------------
    always_comb begin
        remain_clip = (remain >= BND_CNT) ? BND_W : BEAT_W'(remain);
        s_room      = BND_W - {1'b0, cur_s[11:2]};
        d_room      = BND_W - {1'b0, cur_d[11:2]};
    end

    dma_beat_calc u_beat_calc (
        .max_beats (MAX_B),
        .remain    (remain_clip),
        .s_room    (s_room),
        .d_room    (d_room),
        .beats     (beats)
    );

    assign last_burst = (remain == CNT_W'(beats_q));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (!hreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (dma_axi_start) begin
                    state_nxt = (dma_cfg_number == '0) ? DONE : CALC;
                end
            end
            CALC:  state_nxt = ISSUE;
            ISSUE: begin
                if (cmd_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (burst_done) begin
                    state_nxt = last_burst ? DONE : CALC;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        cmd_valid    = (state == ISSUE);
        busy         = (state != IDLE);
        dma_axi_done = (state == DONE);
        dbg_state    = state;
    end

    // ------------------------------------------------------------------
    // Job datapath: cursors, remaining count and the registered command.
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (!hreset) begin
            cur_s     <= '0;
            cur_d     <= '0;
            remain    <= '0;
            beats_q   <= '0;
            cmd_saddr <= '0;
            cmd_daddr <= '0;
            cmd_len   <= '0;
            start_err <= 1'b0;
        end else begin
            // Only IDLE accepts a start; anything else just flags it.
            start_err <= dma_axi_start && (state != IDLE);

            unique case (state)
                IDLE: begin
                    if (dma_axi_start) begin
                        cur_s  <= {dma_cfg_saddr[ADDR_W-1:2], 2'b00};
                        cur_d  <= {dma_cfg_daddr[ADDR_W-1:2], 2'b00};
                        remain <= dma_cfg_number;
                    end
                end
                CALC: begin
                    beats_q   <= beats;
                    cmd_saddr <= cur_s;
                    cmd_daddr <= cur_d;
                    cmd_len   <= LEN_W'(beats - BEAT_W'(1));
                end
                WAIT: begin
                    // Address advance wraps naturally at 2^ADDR_W.
                    if (burst_done) begin
                        cur_s  <= cur_s + ADDR_W'({beats_q, 2'b00});
                        cur_d  <= cur_d + ADDR_W'({beats_q, 2'b00});
                        remain <= remain - CNT_W'(beats_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
